// File: rtl/filter.sv
// Fixed-coefficient 8-tap direct-form FIR low-pass filter, unsigned samples, registered output.
// Define FILTER_SAT_EN to clamp oversized sums to the output maximum instead of wrapping.
module filter #(
    parameter int          DATA_W = 8,
    parameter int          COEF_W = 8,
    parameter int          OUT_W  = 17,
    parameter int unsigned C0     = 10,
    parameter int unsigned C1     = 30,
    parameter int unsigned C2     = 70,
    parameter int unsigned C3     = 120,
    parameter int unsigned C4     = 120,
    parameter int unsigned C5     = 70,
    parameter int unsigned C6     = 30,
    parameter int unsigned C7     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    output logic [OUT_W-1:0]  data_out
);

    localparam int TAPS  = 8;
    // Full-precision accumulator: one product plus three bits of growth for eight terms.
    localparam int ACC_W = DATA_W + COEF_W + 3;

    localparam logic [COEF_W-1:0] COEF [TAPS] = '{
        COEF_W'(C0), COEF_W'(C1), COEF_W'(C2), COEF_W'(C3),
        COEF_W'(C4), COEF_W'(C5), COEF_W'(C6), COEF_W'(C7)
    };

    logic [DATA_W-1:0] x [TAPS];
    logic [ACC_W-1:0]  sum;
    logic [OUT_W-1:0]  out_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x[k] <= '0;
            end
        end else begin
            x[0] <= data_in;
            for (int k = 1; k < TAPS; k++) begin
                x[k] <= x[k-1];
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + (ACC_W'(x[k]) * ACC_W'(COEF[k]));
        end
    end

`ifdef FILTER_SAT_EN
    localparam logic [ACC_W-1:0] SAT_LIMIT = ACC_W'((64'd1 << OUT_W) - 64'd1);

    always_comb begin
        out_next = sum[OUT_W-1:0];
        if (sum > SAT_LIMIT) begin
            out_next = '1;
        end
    end
`else
    // Wrap-around: upper accumulator bits are deliberately dropped.
    logic sum_hi_unused;

    assign sum_hi_unused = ^sum[ACC_W-1:OUT_W];

    always_comb begin
        out_next = sum[OUT_W-1:0];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= out_next;
        end
    end

endmodule

// File: tb/tb_filter.sv
// Scoreboard bench for filter: a convolution model pushes the expected output for every driven
// sample, and the value is popped and compared one edge later when the registered output shows it.
module tb_filter;

    logic        clk;
    logic        reset;
    logic [7:0]  data_in;
    logic [16:0] data_out;
    logic [16:0] data_out_big;

    int checks = 0;
    int errors = 0;

    int unsigned coef [8] = '{10, 30, 70, 120, 120, 70, 30, 10};
    int unsigned hist [8];
    int unsigned sb [$];

    int unsigned sine_tab [32] = '{
        128, 155, 176, 200, 218, 233, 242, 251,
        253, 250, 240, 231, 215, 196, 177, 151,
        128, 104,  80,  57,  40,  23,  14,   5,
          2,   6,  15,  26,  39,  58,  81, 103
    };

    filter dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out)
    );

    // All-255 coefficients make the sum exceed the 17-bit output range.
    filter #(
        .C0(255), .C1(255), .C2(255), .C3(255),
        .C4(255), .C5(255), .C6(255), .C7(255)
    ) dut_big (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out_big)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [19:0] observed,
                               input logic [19:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int unsigned modelSum();
        int unsigned s = 0;
        for (int k = 0; k < 8; k++) begin
            s += coef[k] * hist[k];
        end
        return s % 131072;
    endfunction

    task automatic modelFlush();
        for (int k = 0; k < 8; k++) begin
            hist[k] = 0;
        end
        sb.delete();
        sb.push_back(0);
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] sample);
        int unsigned exp_val;
        data_in = sample;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 20'(sb.size()), 20'd1);
        end else begin
            exp_val = sb.pop_front();
            checkOutput(tag, 20'(data_out), 20'(exp_val));
        end
        for (int k = 7; k > 0; k--) begin
            hist[k] = hist[k-1];
        end
        hist[0] = sample;
        sb.push_back(modelSum());
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 8'(($urandom));
        modelFlush();

        repeat (3) begin
            data_in = 8'($urandom);
            @(posedge clk);
            #1;
            checkOutput("reset_hold", 20'(data_out), 20'd0);
        end

        @(negedge clk);
        reset = 1'b0;
        modelFlush();

        for (int i = 0; i < 4; i++) begin
            applyStimulus("zero_after_reset", 8'd0);
        end

        applyStimulus("impulse", 8'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus("impulse", 8'd0);
        end

        for (int i = 0; i < 12; i++) begin
            applyStimulus("step", 8'd255);
        end
        checkOutput("step_settled", 20'(data_out), 20'd117300);
`ifdef FILTER_SAT_EN
        checkOutput("big_coef_sat", 20'(data_out_big), 20'd131071);
`else
        checkOutput("big_coef_wrap", 20'(data_out_big), 20'd126984);
`endif

        // Asynchronous reset pulse placed between clock edges.
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 20'(data_out), 20'd0);
        checkOutput("async_reset_big", 20'(data_out_big), 20'd0);
        #1;
        reset = 1'b0;
        modelFlush();

        for (int i = 0; i < 10; i++) begin
            applyStimulus("step_after_reset", 8'd255);
        end

        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 32; i++) begin
                applyStimulus("sine", 8'(sine_tab[i] + ($urandom_range(0, 2))));
            end
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus("drain", 8'd0);
        end
        checkOutput("drained", 20'(data_out), 20'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
